mips_cpu_muldiv: RTL and testbench

MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

---
 rtl/mips_cpu_pkg.sv | 21 ++
 rtl/mips_cpu_muldiv.sv | 161 ++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the CPU multiply/divide unit: operation encoding,
// controller states and the iteration count of the bit-serial datapath.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

  localparam int MULDIV_ITERATIONS = 32;
  localparam logic [4:0] MULDIV_LAST_ITER = 5'(MULDIV_ITERATIONS - 1);

endpackage

// File: rtl/mips_cpu_muldiv.sv
// Iterative HI/LO multiply/divide unit. Signed operations run on operand
// magnitudes and the result signs are restored in FIX. FIX takes two cycles:
// the first applies the sign correction to the partial register, and the
// second commits it to HI/LO while pulsing done.
// Multiply and divide share one 64-bit partial register and one 33-bit adder.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state, state_next;
  muldiv_op_t    op_q;
  logic [4:0]    iter;
  logic          fix_step;
  logic [63:0]   acc;
  logic [31:0]   operand_b;
  logic          neg_diff;
  logic          neg_a;
  logic          b_zero;

  muldiv_op_t    op_in;
  logic          in_signed;
  logic          in_a_neg;
  logic          in_b_neg;
  logic [31:0]   in_a_mag;
  logic [31:0]   in_b_mag;

  logic          is_div;
  logic [32:0]   add_a;
  logic [32:0]   add_b;
  logic [33:0]   add_sum;
  logic [63:0]   step_acc;
  logic [63:0]   fix_acc;
  logic [31:0]   fix_quot;
  logic [31:0]   fix_rem;

  assign op_in     = muldiv_op_t'(op);
  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign in_a_neg  = in_signed & a[31];
  assign in_b_neg  = in_signed & b[31];
  assign in_a_mag  = in_a_neg ? (~a + 32'd1) : a;
  assign in_b_mag  = in_b_neg ? (~b + 32'd1) : b;

  // Shared adder: add multiplicand for multiply; subtract divisor for divide,
  // where the carry out means the shifted remainder was >= divisor.
  assign is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign add_a   = is_div ? acc[63:31] : {1'b0, acc[63:32]};
  assign add_b   = is_div ? ~{1'b0, operand_b} : {1'b0, operand_b};
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {33'd0, is_div};

  // One iteration: shift-add multiply step or restoring divide step.
  always_comb begin
    step_acc = acc;
    if (is_div) begin
      if (add_sum[33]) step_acc = {add_sum[31:0], acc[30:0], 1'b1};
      else             step_acc = {acc[62:0], 1'b0};
    end else begin
      if (acc[0]) step_acc = {add_sum[32:0], acc[31:1]};
      else        step_acc = {1'b0, acc[63:1]};
    end
  end

  // Sign restoration; a zero divisor forces an all-ones quotient.
  always_comb begin
    fix_quot = acc[31:0];
    fix_rem  = acc[63:32];
    fix_acc  = acc;
    if (is_div) begin
      if (b_zero)        fix_quot = '1;
      else if (neg_diff) fix_quot = ~acc[31:0] + 32'd1;
      if (neg_a)         fix_rem  = ~acc[63:32] + 32'd1;
      fix_acc = {fix_rem, fix_quot};
    end else if (neg_diff) begin
      fix_acc = ~acc + 64'd1;
    end
  end

  // Controller next-state and busy decode.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (iter == MULDIV_LAST_ITER) state_next = FIX;
      FIX:     if (fix_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Operand capture, iteration, sign fix-up and HI/LO writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_MULT;
      iter      <= 5'd0;
      fix_step  <= 1'b0;
      acc       <= 64'd0;
      operand_b <= 32'd0;
      neg_diff  <= 1'b0;
      neg_a     <= 1'b0;
      b_zero    <= 1'b0;
      done      <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op_in;
            acc       <= {32'd0, in_a_mag};
            operand_b <= in_b_mag;
            neg_diff  <= in_a_neg ^ in_b_neg;
            neg_a     <= in_a_neg;
            b_zero    <= (b == 32'd0);
            iter      <= 5'd0;
            fix_step  <= 1'b0;
          end else begin
            if (mthi) hi <= mt_data;
            if (mtlo) lo <= mt_data;
          end
        end
        RUN: begin
          acc  <= step_acc;
          iter <= iter + 5'd1;
        end
        FIX: begin
          if (!fix_step) begin
            acc      <= fix_acc;
            fix_step <= 1'b1;
          end else begin
            hi       <= acc[63:32];
            lo       <= acc[31:0];
            done     <= 1'b1;
            fix_step <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed self-checking bench for mips_cpu_muldiv.
module tb_mips_cpu_muldiv;
  import mips_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  mips_cpu_muldiv dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .mt_data (mt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Start at a negedge, so the start edge N is the next posedge. withMt also
  // raises mtlo together with start. injectAt>0 pulses start+mthi+mtlo at
  // that in-flight cycle.
  task automatic applyStimulus(input string tag, input logic [1:0] opSel,
                               input logic [31:0] opA, input logic [31:0] opB,
                               input logic [31:0] holdHi, input logic [31:0] holdLo,
                               input logic [31:0] expHi, input logic [31:0] expLo,
                               input logic withMt, input int injectAt);
    logic earlyDone;
    earlyDone = 1'b0;
    @(negedge clk);
    start = 1'b1; op = opSel; a = opA; b = opB;
    mtlo = withMt; mt_data = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
    checkOutput({tag, " busy@N"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 33; i++) begin
      if (i == injectAt) begin
        start = 1'b1; op = OP_MULTU; mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hCAFEF00D;
      end
      @(negedge clk);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      earlyDone = earlyDone | done;
      if (i == 1 || i == 33) begin
        checkOutput({tag, " hold hi"}, hi, holdHi);
        checkOutput({tag, " hold lo"}, lo, holdLo);
      end
    end
    checkOutput({tag, " busy@N+33"}, 32'(busy), 32'd1);
    checkOutput({tag, " early done"}, 32'(earlyDone), 32'd0);
    @(negedge clk);
    checkOutput({tag, " done@N+34"}, 32'(done), 32'd1);
    checkOutput({tag, " busy@N+34"}, 32'(busy), 32'd0);
    checkOutput({tag, " hi"}, hi, expHi);
    checkOutput({tag, " lo"}, lo, expLo);
    @(negedge clk);
    checkOutput({tag, " done@N+35"}, 32'(done), 32'd0);
    checkOutput({tag, " busy@N+35"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic sawDone;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; mt_data = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    reset = 1'b0;

    applyStimulus("multu max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'd0, 32'd0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
    applyStimulus("mult -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7,
                  32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
    applyStimulus("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2,
                  32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    applyStimulus("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE,
                  32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
    applyStimulus("divu 100/0", OP_DIVU, 32'd100, 32'd0,
                  32'h00000001, 32'hFFFFFFFD, 32'd100, 32'hFFFFFFFF, 1'b0, 0);
    applyStimulus("div -7/0", OP_DIV, 32'hFFFFFFF9, 32'd0,
                  32'd100, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, 0);
    applyStimulus("divu big/16", OP_DIVU, 32'hFFFFFFFF, 32'd16,
                  32'hFFFFFFF9, 32'hFFFFFFFF, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 0);
    applyStimulus("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
                  32'h0000000F, 32'h0FFFFFFF, 32'd0, 32'h80000000, 1'b0, 0);

    // MTHI while idle lands at the next edge and leaves LO alone.
    @(negedge clk);
    mthi = 1'b1; mt_data = 32'h12345678;
    @(negedge clk);
    mthi = 1'b0;
    checkOutput("mthi hi", hi, 32'h12345678);
    checkOutput("mthi lo", lo, 32'h80000000);

    // start+mtlo together drops the mtlo; a start+mt pulse mid-run is ignored.
    applyStimulus("divu 7/2 mt", OP_DIVU, 32'd7, 32'd2,
                  32'h12345678, 32'h80000000, 32'd1, 32'd3, 1'b1, 5);
    repeat (3) @(negedge clk);
    checkOutput("no queued start", 32'(busy), 32'd0);

    // MTHI and MTLO together write both registers.
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h55AA55AA;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checkOutput("mt both hi", hi, 32'h55AA55AA);
    checkOutput("mt both lo", lo, 32'h55AA55AA);

    // Reset ten cycles into a MULTU aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'h00010000; b = 32'h00010000;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      sawDone = sawDone | done;
    end
    checkOutput("abort no done", 32'(sawDone), 32'd0);
    applyStimulus("multu after rst", OP_MULTU, 32'd12345, 32'd6789,
                  32'd0, 32'd0, 32'd0, 32'h04FED79D, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
